// File: rtl/pa_clint_regs.sv
`default_nettype none
// ============================================================================
// Module      : pa_clint_regs
// Description : CLINT register/timer core - msip, mtimecmp, 64-bit mtime
//               counter and the machine software/timer interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
module pa_clint_regs #(
    parameter int unsigned  TICK_SYNC    = 1,
    parameter logic [63:0]  MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        busif_regs_msip_sel,
    input  logic        busif_regs_mtimecmp_lo_sel,
    input  logic        busif_regs_mtimecmp_hi_sel,
    input  logic        busif_regs_write_vld,
    input  logic [31:0] busif_regs_wdata,
    input  logic        sysio_clint_mtime_tick,
    input  logic        sysio_clint_mtime_stop,
    output logic [31:0] msip_value,
    output logic [31:0] mtimecmp_lo_value,
    output logic [31:0] mtimecmp_hi_value,
    output logic [31:0] mtime_lo_value,
    output logic [31:0] mtime_hi_value,
    output logic        clint_cpu_sw_int,
    output logic        clint_cpu_tmr_int
);

    logic        msip_q;
    logic        msip_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic        tmr_int_q;
    logic        w_inc;
    logic        w_msip_wr;
    logic        w_cmp_lo_wr;
    logic        w_cmp_hi_wr;

    // ------------------------------------------------------------------
    // Time-base increment source
    // ------------------------------------------------------------------
    generate
        if (TICK_SYNC != 0) begin : g_tick_sync
            logic sync1_q;
            logic sync2_q;
            logic prev_q;

            always_ff @(posedge forever_cpuclk) begin
                if (cpurst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    prev_q  <= 1'b0;
                end else begin
                    sync1_q <= sysio_clint_mtime_tick;
                    sync2_q <= sync1_q;
                    prev_q  <= sync2_q;
                end
            end

            assign w_inc = sync2_q & ~prev_q;
        end else begin : g_tick_direct
            assign w_inc = sysio_clint_mtime_tick;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign w_msip_wr   = busif_regs_write_vld & busif_regs_msip_sel;
    assign w_cmp_lo_wr = busif_regs_write_vld & busif_regs_mtimecmp_lo_sel;
    assign w_cmp_hi_wr = busif_regs_write_vld & busif_regs_mtimecmp_hi_sel;

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q;

        if (w_msip_wr) begin
            msip_d = busif_regs_wdata[0];
        end

        if (w_cmp_lo_wr) begin
            mtimecmp_d[31:0] = busif_regs_wdata;
        end

        if (w_cmp_hi_wr) begin
            mtimecmp_d[63:32] = busif_regs_wdata;
        end

        // Events arriving while stopped are dropped, never accumulated.
        if (w_inc && !sysio_clint_mtime_stop) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= MTIMECMP_RST;
            mtime_q    <= 64'd0;
            tmr_int_q  <= 1'b0;
        end else begin
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            tmr_int_q  <= (mtime_q >= mtimecmp_q);
        end
    end

    // ------------------------------------------------------------------
    // Read values and interrupt lines
    // ------------------------------------------------------------------
    assign msip_value        = {31'd0, msip_q};
    assign mtimecmp_lo_value = mtimecmp_q[31:0];
    assign mtimecmp_hi_value = mtimecmp_q[63:32];
    assign mtime_lo_value    = mtime_q[31:0];
    assign mtime_hi_value    = mtime_q[63:32];
    assign clint_cpu_sw_int  = msip_q;
    assign clint_cpu_tmr_int = tmr_int_q;

endmodule
`default_nettype wire

// File: tb/tb_pa_clint_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pa_clint_regs
// Description : Bench for pa_clint_regs; one instance per tick mode, shared
//               stimulus, compared every cycle against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pa_clint_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        msip_sel;
    logic        lo_sel;
    logic        hi_sel;
    logic        wv;
    logic [31:0] wdata;
    logic        tick;
    logic        stop;

    logic [31:0] a_msip, a_cmplo, a_cmphi, a_tlo, a_thi;
    logic        a_sw, a_tmr;
    logic [31:0] s_msip, s_cmplo, s_cmphi, s_tlo, s_thi;
    logic        s_sw, s_tmr;

    int nchk  = 0;
    int nfail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    pa_clint_regs #(.TICK_SYNC(1), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) u_async (
        .forever_cpuclk             (clk),
        .cpurst                     (rst),
        .busif_regs_msip_sel        (msip_sel),
        .busif_regs_mtimecmp_lo_sel (lo_sel),
        .busif_regs_mtimecmp_hi_sel (hi_sel),
        .busif_regs_write_vld       (wv),
        .busif_regs_wdata           (wdata),
        .sysio_clint_mtime_tick     (tick),
        .sysio_clint_mtime_stop     (stop),
        .msip_value                 (a_msip),
        .mtimecmp_lo_value          (a_cmplo),
        .mtimecmp_hi_value          (a_cmphi),
        .mtime_lo_value             (a_tlo),
        .mtime_hi_value             (a_thi),
        .clint_cpu_sw_int           (a_sw),
        .clint_cpu_tmr_int          (a_tmr)
    );

    pa_clint_regs #(.TICK_SYNC(0), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) u_sync (
        .forever_cpuclk             (clk),
        .cpurst                     (rst),
        .busif_regs_msip_sel        (msip_sel),
        .busif_regs_mtimecmp_lo_sel (lo_sel),
        .busif_regs_mtimecmp_hi_sel (hi_sel),
        .busif_regs_write_vld       (wv),
        .busif_regs_wdata           (wdata),
        .sysio_clint_mtime_tick     (tick),
        .sysio_clint_mtime_stop     (stop),
        .msip_value                 (s_msip),
        .mtimecmp_lo_value          (s_cmplo),
        .mtimecmp_hi_value          (s_cmphi),
        .mtime_lo_value             (s_tlo),
        .mtime_hi_value             (s_thi),
        .clint_cpu_sw_int           (s_sw),
        .clint_cpu_tmr_int          (s_tmr)
    );

    // Reference model: index 0 = synchronised tick, index 1 = direct tick.
    // tick_hist[j] is the tick level seen j edges ago; a synchronised
    // increment happens two edges after a sampled 0->1 transition.
    logic [63:0] m_time [2];
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_tmr  [2];
    logic [3:1]  tick_hist;

    always @(posedge clk) begin : p_model
        logic nt0, nt1, inc_a;
        if (rst) begin
            m_time[0] = 64'd0;
            m_time[1] = 64'd0;
            m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip    = 1'b0;
            m_tmr[0]  = 1'b0;
            m_tmr[1]  = 1'b0;
            tick_hist = 3'b000;
        end else begin
            nt0   = (m_time[0] >= m_cmp);
            nt1   = (m_time[1] >= m_cmp);
            inc_a = tick_hist[2] && !tick_hist[3];
            if (!stop && inc_a) m_time[0] = m_time[0] + 64'd1;
            if (!stop && tick)  m_time[1] = m_time[1] + 64'd1;
            if (wv) begin
                if (msip_sel)    m_msip       = wdata[0];
                else if (lo_sel) m_cmp[31:0]  = wdata;
                else if (hi_sel) m_cmp[63:32] = wdata;
            end
            m_tmr[0]  = nt0;
            m_tmr[1]  = nt1;
            tick_hist = {tick_hist[2:1], tick};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : p_compare
        #1;
        if (chk_en) begin
            chk("a_mtime",  {a_thi, a_tlo},     m_time[0]);
            chk("a_cmp",    {a_cmphi, a_cmplo}, m_cmp);
            chk("a_msip",   64'(a_msip),        64'(m_msip));
            chk("a_sw",     64'(a_sw),          64'(m_msip));
            chk("a_tmr",    64'(a_tmr),         64'(m_tmr[0]));
            chk("s_mtime",  {s_thi, s_tlo},     m_time[1]);
            chk("s_cmp",    {s_cmphi, s_cmplo}, m_cmp);
            chk("s_msip",   64'(s_msip),        64'(m_msip));
            chk("s_sw",     64'(s_sw),          64'(m_msip));
            chk("s_tmr",    64'(s_tmr),         64'(m_tmr[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        wv = 1'b0; msip_sel = 1'b0; lo_sel = 1'b0; hi_sel = 1'b0; wdata = 32'd0;
    endtask

    // which: 0 msip, 1 mtimecmp_lo, 2 mtimecmp_hi, 3 no select
    task automatic wr(input int which, input logic [31:0] d);
        wv = 1'b1; wdata = d;
        msip_sel = (which == 0); lo_sel = (which == 1); hi_sel = (which == 2);
        cyc(1);
        idle();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; stop = 1'b0;
        idle();
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset values
        chk("rst_mtime", {s_thi, s_tlo}, 64'd0);
        chk("rst_cmp",   {s_cmphi, s_cmplo}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_msip",  64'(s_msip), 64'd0);
        chk("rst_ints",  64'({s_sw, s_tmr, a_sw, a_tmr}), 64'd0);

        // msip
        wr(0, 32'hFFFF_FFFF);
        chk("msip_set", 64'({s_msip, s_sw}), {31'd0, 32'h1, 1'b1});
        wr(0, 32'h0);
        chk("msip_clr", 64'({s_msip, s_sw}), 64'd0);
        wr(3, 32'h1);
        chk("msip_nosel", 64'({a_msip, a_sw}), 64'd0);

        // Timer compare with direct tick
        wr(1, 32'd5);
        wr(2, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; cyc(1); tick = 1'b0;
            if (i < 4) cyc(1);
        end
        chk("cmp_at5_mtime", 64'(s_tlo), 64'd5);
        chk("cmp_at5_tmr0",  64'(s_tmr), 64'd0);
        cyc(1);
        chk("cmp_tmr_rise",  64'(s_tmr), 64'd1);
        wr(1, 32'd10);
        chk("cmp_lo10",      64'(s_cmplo), 64'd10);
        chk("cmp_tmr_hold",  64'(s_tmr), 64'd1);
        cyc(1);
        chk("cmp_tmr_fall",  64'(s_tmr), 64'd0);

        // Wrap
        wr(1, 32'hFFFF_FFFF);
        wr(2, 32'hFFFF_FFFF);
        force u_sync.mtime_q = 64'hFFFF_FFFF_FFFF_FFFE;
        m_time[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release u_sync.mtime_q;
        tick = 1'b1;
        cyc(1);
        chk("wrap_max",   {s_thi, s_tlo}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_tmr0",  64'(s_tmr), 64'd0);
        cyc(1);
        tick = 1'b0;
        chk("wrap_zero",  {s_thi, s_tlo}, 64'd0);
        chk("wrap_tmr1",  64'(s_tmr), 64'd1);
        cyc(1);
        chk("wrap_tmr_clr", 64'(s_tmr), 64'd0);

        // Synchronised tick: one increment at N+2 for a 4-clock pulse
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(3);
        tick = 1'b1;
        cyc(1); chk("sync_n",   64'(a_tlo), 64'd0);
        cyc(1); chk("sync_n1",  64'(a_tlo), 64'd0);
        cyc(1); chk("sync_n2",  64'(a_tlo), 64'd1);
        cyc(1); tick = 1'b0;
        cyc(4); chk("sync_one", 64'(a_tlo), 64'd1);

        // Stop discards events
        stop = 1'b1; tick = 1'b1; cyc(4); tick = 1'b0; cyc(4);
        stop = 1'b0; cyc(2);
        chk("stop_drop", {a_thi, a_tlo}, 64'd1);

        // mtimecmp_hi write coinciding with an increment edge
        tick = 1'b1; cyc(2);
        wv = 1'b1; hi_sel = 1'b1; wdata = 32'h1234_5678;
        cyc(1); idle();
        chk("simul_mtime", {a_thi, a_tlo}, 64'd2);
        chk("simul_cmphi", 64'(a_cmphi), 64'h1234_5678);
        tick = 1'b0; cyc(4);

        // Reset mid-operation with tick high across release
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(2);
        for (int i = 0; i < 100; i++) begin
            tick = 1'b1; cyc(2); tick = 1'b0; cyc(2);
        end
        cyc(3);
        chk("pre_rst_mtime", {a_thi, a_tlo}, 64'd100);
        wr(0, 32'h1);
        chk("pre_rst_msip", 64'(a_msip), 64'd1);
        tick = 1'b1; cyc(1);
        rst = 1'b1; cyc(1);
        chk("mid_rst_mtime", {a_thi, a_tlo}, 64'd0);
        chk("mid_rst_regs",  64'({a_msip[0], a_sw, a_tmr}), 64'd0);
        chk("mid_rst_cmp",   {a_cmphi, a_cmplo}, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b0;
        cyc(1); chk("rel_r",  64'(a_tlo), 64'd0);
        cyc(1); chk("rel_r1", 64'(a_tlo), 64'd0);
        cyc(1); chk("rel_r2", 64'(a_tlo), 64'd1);
        cyc(3); chk("rel_one", {a_thi, a_tlo}, 64'd1);
        tick = 1'b0; cyc(2);

        // Randomised phase
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            idle();
            rst  = ($urandom_range(0, 199) == 0);
            stop = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) tick = ~tick;
            r = $urandom_range(0, 9);
            case (r)
                0: begin wv = 1'b1; msip_sel = 1'b1; wdata = $urandom; end
                1: begin wv = 1'b1; lo_sel = 1'b1; wdata = $urandom; end
                2: begin wv = 1'b1; hi_sel = 1'b1; wdata = $urandom; end
                3: begin wv = 1'b1; wdata = $urandom; end
                4: begin wv = 1'b1; hi_sel = 1'b1; wdata = m_time[$urandom_range(0, 1)][63:32]; end
                5: begin
                    wv = 1'b1; lo_sel = 1'b1;
                    wdata = m_time[$urandom_range(0, 1)][31:0] + 32'($urandom_range(0, 6)) - 32'd3;
                end
                default: ;
            endcase
            cyc(1);
        end
        idle(); rst = 1'b0; stop = 1'b0; tick = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
